// File: rtl/call_stack_ctrl_if.sv
// Bus bundle for call_stack_ctrl: push/pop/flush controls in, stack status out.
// Optional macro STACK_CKPT_EN adds the ckpt/restore checkpoint controls.
interface call_stack_ctrl_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic             clear;
    logic             err_clear;
    logic [WIDTH-1:0] push_data;
`ifdef STACK_CKPT_EN
    logic             ckpt;
    logic             restore;
`endif
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, clear, err_clear, push_data,
`ifdef STACK_CKPT_EN
        output ckpt, restore,
`endif
        input  top, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, clear, err_clear, push_data,
`ifdef STACK_CKPT_EN
        input  ckpt, restore,
`endif
        output top, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/call_stack_ctrl.sv
// Return-address stack for the RET path of PC select.
// Circular storage indexed by sp (next free slot); top is combinational so the
// PC mux can consume it in the same cycle as a pop.
// OVF_MODE: 0 = a push on a full stack overwrites the oldest entry, 1 = rejected.
// Optional macro STACK_CKPT_EN adds a {sp, count} checkpoint shadow with
// ckpt/restore controls (entry data itself is never restored).
module call_stack_ctrl #(
    parameter int WIDTH    = 12,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    call_stack_ctrl_if.slave      stk
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam bit WRAP = (OVF_MODE == 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp, sp_nxt, sp_m1, wr_addr;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             wr_en, ovf_set, udf_set;
    logic             overflow_q, underflow_q;
    logic             is_empty, is_full;
`ifdef STACK_CKPT_EN
    logic [PW-1:0]    shd_sp;
    logic [CW-1:0]    shd_cnt;
    logic             shd_ld;
`endif

    assign sp_m1    = sp - 1'b1;
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);

    // Next pointer/count, write strobe and error strobes; clear beats everything.
    always_comb begin
        sp_nxt  = sp;
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_addr = sp;
        ovf_set = 1'b0;
        udf_set = 1'b0;
`ifdef STACK_CKPT_EN
        shd_ld  = 1'b0;
`endif
        if (stk.clear) begin
            sp_nxt  = '0;
            cnt_nxt = '0;
        end
`ifdef STACK_CKPT_EN
        else if (stk.restore) begin
            sp_nxt  = shd_sp;
            cnt_nxt = shd_cnt;
        end
        else if (stk.ckpt) begin
            shd_ld = 1'b1;
        end
`endif
        else begin
            case ({stk.push, stk.pop})
                2'b10: begin
                    if (!is_full) begin
                        wr_en   = 1'b1;
                        sp_nxt  = sp + 1'b1;
                        cnt_nxt = cnt + 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                        if (WRAP) begin
                            wr_en  = 1'b1;
                            sp_nxt = sp + 1'b1;
                        end
                    end
                end
                2'b01: begin
                    if (!is_empty) begin
                        sp_nxt  = sp_m1;
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        udf_set = 1'b1;
                    end
                end
                2'b11: begin
                    // Replace-top on a live stack; on an empty one it degrades to a push.
                    wr_en = 1'b1;
                    if (!is_empty) begin
                        wr_addr = sp_m1;
                    end else begin
                        sp_nxt  = sp + 1'b1;
                        cnt_nxt = cnt + 1'b1;
                        udf_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pointer, count and sticky flags; a new error wins over err_clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp          <= '0;
            cnt         <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp          <= sp_nxt;
            cnt         <= cnt_nxt;
            overflow_q  <= ovf_set | (overflow_q  & ~stk.err_clear);
            underflow_q <= udf_set | (underflow_q & ~stk.err_clear);
        end
    end

    // Entry storage; contents are don't-care after reset so no reset term.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= stk.push_data;
    end

`ifdef STACK_CKPT_EN
    // Checkpoint shadow of the pointer state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shd_sp  <= '0;
            shd_cnt <= '0;
        end else if (shd_ld) begin
            shd_sp  <= sp;
            shd_cnt <= cnt;
        end
    end
`endif

    assign stk.top       = is_empty ? '0 : mem[sp_m1];
    assign stk.count     = cnt;
    assign stk.empty     = is_empty;
    assign stk.full      = is_full;
    assign stk.overflow  = overflow_q;
    assign stk.underflow = underflow_q;
endmodule

// File: tb/tb_call_stack_ctrl.sv
// Bench for call_stack_ctrl: two instances (wrap and reject policy) driven in
// lockstep, checked against queue-based models plus a table of directed vectors.
module tb_call_stack_ctrl;
    localparam int W = 12;
    localparam int D = 8;

    typedef logic [W-1:0] q_t [$];

    typedef struct {
        bit         push;
        bit         pop;
        bit         clr;
        bit         ec;
        logic [W-1:0] d;
        logic [W-1:0] e_top;
        int         e_cnt;
        bit         e_emp;
        bit         e_full;
        bit         e_ovf;
        bit         e_udf;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic push, pop, clear, err_clear;
    logic [W-1:0] push_data;
`ifdef STACK_CKPT_EN
    logic ckpt, restore;
`endif

    int checks = 0;
    int errors = 0;

    q_t q0, q1;
    bit o0, u0, o1, u1;
    vec_t tbl [$];

    always #5 clk = ~clk;

    call_stack_ctrl_if #(.WIDTH(W), .DEPTH(D)) s0 ();
    call_stack_ctrl_if #(.WIDTH(W), .DEPTH(D)) s1 ();

    assign s0.push = push;       assign s1.push = push;
    assign s0.pop = pop;         assign s1.pop = pop;
    assign s0.clear = clear;     assign s1.clear = clear;
    assign s0.err_clear = err_clear; assign s1.err_clear = err_clear;
    assign s0.push_data = push_data; assign s1.push_data = push_data;
`ifdef STACK_CKPT_EN
    assign s0.ckpt = ckpt;       assign s1.ckpt = ckpt;
    assign s0.restore = restore; assign s1.restore = restore;
`endif

    call_stack_ctrl #(.WIDTH(W), .DEPTH(D), .OVF_MODE(0)) u_wrap (
        .clk(clk), .reset(reset), .stk(s0.slave));
    call_stack_ctrl #(.WIDTH(W), .DEPTH(D), .OVF_MODE(1)) u_rej (
        .clk(clk), .reset(reset), .stk(s1.slave));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stack behaviour expressed on a queue: back = top, front = oldest.
    task automatic mdl(input bit reject, inout q_t q, inout bit o, inout bit u);
        bit so = 0, su = 0;
        if (!clear) begin
            if (push && !pop) begin
                if (q.size() < D) q.push_back(push_data);
                else begin
                    so = 1;
                    if (!reject) begin
                        void'(q.pop_front());
                        q.push_back(push_data);
                    end
                end
            end else if (pop && !push) begin
                if (q.size() > 0) void'(q.pop_back());
                else su = 1;
            end else if (push && pop) begin
                if (q.size() > 0) q[q.size()-1] = push_data;
                else begin
                    q.push_back(push_data);
                    su = 1;
                end
            end
        end else begin
            q.delete();
        end
        o = so | (o & !err_clear);
        u = su | (u & !err_clear);
    endtask

    task automatic cmp_models();
        int t0, t1;
        t0 = (q0.size() > 0) ? int'(q0[q0.size()-1]) : 0;
        t1 = (q1.size() > 0) ? int'(q1[q1.size()-1]) : 0;
        chk("wrap.top",   int'(s0.top),   t0);
        chk("wrap.count", int'(s0.count), q0.size());
        chk("wrap.empty", int'(s0.empty), int'(q0.size() == 0));
        chk("wrap.full",  int'(s0.full),  int'(q0.size() == D));
        chk("wrap.ovf",   int'(s0.overflow),  int'(o0));
        chk("wrap.udf",   int'(s0.underflow), int'(u0));
        chk("rej.top",    int'(s1.top),   t1);
        chk("rej.count",  int'(s1.count), q1.size());
        chk("rej.empty",  int'(s1.empty), int'(q1.size() == 0));
        chk("rej.full",   int'(s1.full),  int'(q1.size() == D));
        chk("rej.ovf",    int'(s1.overflow),  int'(o1));
        chk("rej.udf",    int'(s1.underflow), int'(u1));
    endtask

    task automatic step(input bit p, input bit po, input bit c, input bit ec, input logic [W-1:0] d);
        push = p; pop = po; clear = c; err_clear = ec; push_data = d;
        @(posedge clk);
        mdl(1'b0, q0, o0, u0);
        mdl(1'b1, q1, o1, u1);
        #1;
        cmp_models();
    endtask

    task automatic idle_inputs();
        push = 0; pop = 0; clear = 0; err_clear = 0; push_data = '0;
`ifdef STACK_CKPT_EN
        ckpt = 0; restore = 0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        #12;
        reset = 1'b1;
        q0.delete(); q1.delete();
        o0 = 0; u0 = 0; o1 = 0; u1 = 0;
    endtask

    task automatic add(input bit p, input bit po, input bit c, input bit ec, input logic [W-1:0] d,
                       input logic [W-1:0] t, input int n, input bit ov, input bit ud);
        vec_t v;
        v.push = p; v.pop = po; v.clr = c; v.ec = ec; v.d = d;
        v.e_top = t; v.e_cnt = n; v.e_emp = (n == 0); v.e_full = (n == D);
        v.e_ovf = ov; v.e_udf = ud;
        tbl.push_back(v);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // Directed vectors for the wrap-policy instance, from reset.
        add(1,0,0,0,12'h010, 12'h010, 1, 0, 0);
        add(1,0,0,0,12'h020, 12'h020, 2, 0, 0);
        add(1,0,0,0,12'h030, 12'h030, 3, 0, 0);
        add(0,1,0,0,12'h000, 12'h020, 2, 0, 0);
        add(0,1,0,0,12'h000, 12'h010, 1, 0, 0);
        add(0,1,0,0,12'h000, 12'h000, 0, 0, 0);
        add(0,1,0,0,12'h000, 12'h000, 0, 0, 1);
        add(0,0,0,1,12'h000, 12'h000, 0, 0, 0);
        add(1,0,0,0,12'h100, 12'h100, 1, 0, 0);
        add(1,1,0,0,12'h200, 12'h200, 1, 0, 0);
        add(0,1,0,0,12'h000, 12'h000, 0, 0, 0);
        add(1,1,0,0,12'h055, 12'h055, 1, 0, 1);
        add(0,1,0,1,12'h000, 12'h000, 0, 0, 0);
        add(1,0,1,0,12'h0AA, 12'h000, 0, 0, 0);
        for (int i = 1; i <= 9; i++)
            add(1,0,0,0,W'(i), W'(i), (i > D) ? D : i, (i > D), 0);
        for (int i = 1; i <= 8; i++)
            add(0,1,0,0,12'h000, (i < 8) ? W'(9 - i) : W'(0), 8 - i, 1, 0);
        add(0,1,0,1,12'h000, 12'h000, 0, 0, 1);
        add(0,0,0,1,12'h000, 12'h000, 0, 0, 0);

        do_reset();
        #1;
        cmp_models();
        chk("reset.top",   int'(s0.top), 0);
        chk("reset.empty", int'(s0.empty), 1);

        foreach (tbl[k]) begin
            step(tbl[k].push, tbl[k].pop, tbl[k].clr, tbl[k].ec, tbl[k].d);
            chk($sformatf("tbl%0d.top", k),   int'(s0.top),   int'(tbl[k].e_top));
            chk($sformatf("tbl%0d.count", k), int'(s0.count), tbl[k].e_cnt);
            chk($sformatf("tbl%0d.empty", k), int'(s0.empty), int'(tbl[k].e_emp));
            chk($sformatf("tbl%0d.full", k),  int'(s0.full),  int'(tbl[k].e_full));
            chk($sformatf("tbl%0d.ovf", k),   int'(s0.overflow),  int'(tbl[k].e_ovf));
            chk($sformatf("tbl%0d.udf", k),   int'(s0.underflow), int'(tbl[k].e_udf));
        end

        // Overflow policies side by side, then replace-top on a full stack.
        do_reset();
        for (int i = 1; i <= 9; i++) step(1, 0, 0, 0, W'(i));
        chk("rej9.count", int'(s1.count), 8);
        chk("rej9.top",   int'(s1.top), 8);
        chk("rej9.ovf",   int'(s1.overflow), 1);
        chk("wrap9.top",  int'(s0.top), 9);
        step(0, 0, 0, 1, '0);
        chk("rej.ovf_cleared", int'(s1.overflow), 0);
        step(1, 1, 0, 0, 12'h3C3);
        chk("full_rep.top",  int'(s0.top), 12'h3C3);
        chk("full_rep.ovf",  int'(s0.overflow), 0);
        chk("full_rep.cnt",  int'(s1.count), 8);

        // Random traffic against the models.
        for (int n = 0; n < 600; n++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 11) == 0,
                 W'($urandom));

        // Asynchronous reset with no clock edge.
        step(1, 0, 0, 0, 12'h777);
        #2;
        reset = 1'b0;
        #1;
        chk("async.count", int'(s0.count), 0);
        chk("async.top",   int'(s0.top), 0);
        chk("async.empty", int'(s1.empty), 1);
        chk("async.ovf",   int'(s0.overflow), 0);
        #2;
        reset = 1'b1;
        q0.delete(); q1.delete();
        o0 = 0; u0 = 0; o1 = 0; u1 = 0;
        step(0, 0, 0, 0, '0);

`ifdef STACK_CKPT_EN
        // Checkpoint/restore of pointer state; models are not used past here.
        do_reset();
        push = 1; push_data = 12'hA0A; @(posedge clk); #1;
        push = 0; ckpt = 1; @(posedge clk); #1;
        ckpt = 0; push = 1; push_data = 12'hB0B; @(posedge clk); #1;
        push_data = 12'hC0C; @(posedge clk); #1;
        chk("ckpt.pre_cnt", int'(s0.count), 3);
        restore = 1; @(posedge clk); #1;
        restore = 0; push = 0;
        chk("ckpt.count", int'(s0.count), 1);
        chk("ckpt.top",   int'(s0.top), 12'hA0A);
        chk("ckpt.rej_top", int'(s1.top), 12'hA0A);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
